// File: rtl/pipeline_3_memory_pkg.sv
// Shared definitions for the pipeline memory stage: control-word bit map,
// access FSM states, register layouts and the overflow rule for status flags.
package pipeline_3_memory_pkg;

    localparam int unsigned CTRL_W        = 22;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned DEST_W        = 3;
    localparam int unsigned CNT_W         = 8;

    localparam int unsigned BIT_ALUOP_LO  = 6;
    localparam int unsigned BIT_LOADS     = 8;
    localparam int unsigned BIT_MEM_READ  = 11;
    localparam int unsigned BIT_MEM_WRITE = 12;
    localparam int unsigned BIT_REG_WRITE = 13;
    localparam int unsigned BIT_DEST_LO   = 14;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = 8'd255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] control;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] data_rd;
        logic              rm_hi;
        logic              rn_hi;
    } in_reg_t;

    typedef struct packed {
        logic              wb_en;
        logic [DEST_W-1:0] wb_num;
        logic [DATA_W-1:0] wb_data;
        logic [CTRL_W-1:0] control;
    } wb_reg_t;

    // Signed overflow from operand and result sign bits: op 00 is add, op 01 is subtract.
    function automatic logic calc_overflow(input logic [1:0] alu_op, input logic rn_hi,
                                           input logic rm_hi, input logic res_hi);
        case (alu_op)
            2'b00:   return (rn_hi == rm_hi) && (res_hi != rn_hi);
            2'b01:   return (rn_hi != rm_hi) && (res_hi != rn_hi);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_3_memory_mem_access_ctrl.sv
// Memory handshake FSM with wait counter: zero-stall on same-cycle ack,
// stalls while waiting, and locks into FAULT after WAIT_LIMIT unacked cycles.
module mem_access_ctrl
    import pipeline_3_memory_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic access,
    input  logic mem_ack,
    output logic mem_req,
    output logic stall,
    output logic fault
);

    mem_state_t       state;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !mem_ack) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LIMIT - 8'd1) begin
                        state    <= FAULT;
                        wait_cnt <= WAIT_LIMIT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                FAULT: ;
                default: state <= IDLE;
            endcase
        end
    end

    // Request and stall are combinational so a same-cycle ack costs no stall.
    always_comb begin
        mem_req = 1'b0;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                mem_req = access;
                stall   = access && !mem_ack;
            end
            WAIT: begin
                mem_req = 1'b1;
                stall   = !mem_ack;
            end
            FAULT: stall = 1'b1;
            default: ;
        endcase
    end

    assign fault = (state == FAULT);

endmodule

// File: rtl/vDFF.sv
// Plain width-parameterised D flip-flop bank; reset and hold are muxed in by the caller.
module vDFF #(
    parameter int unsigned N = 1
) (
    input  logic         clk,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        q <= d;
    end

endmodule

// File: rtl/pipeline_3_memory.sv
// Pipeline memory stage: input register, memory handshake and writeback register.
// Optional status flags are built only when STATUS_FLAGS_EN is defined.
module pipeline_3_memory
    import pipeline_3_memory_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] control_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] data_Rd_in,
    input  logic              highbit_shifted_Rm_in,
    input  logic              highbit_data_Rn_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_en,
    output logic [DEST_W-1:0] wb_num,
    output logic [DATA_W-1:0] wb_data,
    output logic [CTRL_W-1:0] control_out,
    output logic              flag_Z,
    output logic              flag_N,
    output logic              flag_V,
    output logic              mem_fault
);

    in_reg_t in_d, in_q;
    wb_reg_t wb_d, wb_q;
    logic    mem_read, mem_write, reg_write, access;

    always_comb begin
        if (rst) begin
            in_d = '0;
        end else if (stall) begin
            in_d = in_q;
        end else begin
            in_d = '{control: control_in, result: result_in, data_rd: data_Rd_in,
                     rm_hi: highbit_shifted_Rm_in, rn_hi: highbit_data_Rn_in};
        end
    end

    vDFF #(.N($bits(in_reg_t))) u_in_reg (.clk(clk), .d(in_d), .q(in_q));

    assign mem_read  = in_q.control[BIT_MEM_READ];
    assign mem_write = in_q.control[BIT_MEM_WRITE];
    assign reg_write = in_q.control[BIT_REG_WRITE];
    assign access    = mem_read || mem_write;

    assign mem_we    = mem_write;
    assign mem_addr  = in_q.result;
    assign mem_wdata = in_q.data_rd;

    mem_access_ctrl u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .access  (access),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .stall   (stall),
        .fault   (mem_fault)
    );

    // A read+write access is performed as a write and never writes back.
    always_comb begin
        wb_d = '0;
        if (!rst && !stall) begin
            wb_d.wb_en   = reg_write && !(mem_read && mem_write);
            wb_d.wb_num  = in_q.control[BIT_DEST_LO +: DEST_W];
            wb_d.wb_data = (mem_read && !mem_write) ? mem_rdata : in_q.result;
            wb_d.control = in_q.control;
        end
    end

    vDFF #(.N($bits(wb_reg_t))) u_wb_reg (.clk(clk), .d(wb_d), .q(wb_q));

    assign wb_en       = wb_q.wb_en;
    assign wb_num      = wb_q.wb_num;
    assign wb_data     = wb_q.wb_data;
    assign control_out = wb_q.control;

`ifdef STATUS_FLAGS_EN
    logic [2:0] flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (in_q.control[BIT_LOADS] && !stall) begin
            flags_q <= {in_q.result == '0,
                        in_q.result[DATA_W-1],
                        calc_overflow(in_q.control[BIT_ALUOP_LO +: 2], in_q.rn_hi,
                                      in_q.rm_hi, in_q.result[DATA_W-1])};
        end
    end

    assign flag_Z = flags_q[2];
    assign flag_N = flags_q[1];
    assign flag_V = flags_q[0];
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{in_q.control[BIT_LOADS], in_q.control[BIT_ALUOP_LO +: 2],
                                  in_q.rm_hi, in_q.rn_hi};

    assign flag_Z = 1'b0;
    assign flag_N = 1'b0;
    assign flag_V = 1'b0;
`endif

endmodule

// File: doc/pipeline_3_memory.md
PIPELINE_3_MEMORY -- requirements
Module: pipeline_3_memory

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports control_in (input, 22), result_in (input, 16), data_Rd_in (input, 16), highbit_shifted_Rm_in (input, 1) and highbit_data_Rn_in (input, 1), all driven by the execute stage.
REQ-004 SHALL have port stall, output, 1; when high, the execute and earlier stages hold their registers.
REQ-005 SHALL have memory ports: mem_req (output, 1), mem_we (output, 1), mem_addr (output, 16), mem_wdata (output, 16), mem_rdata (input, 16), mem_ack (input, 1).
REQ-006 SHALL have writeback ports: wb_en (output, 1), wb_num (output, 3), wb_data (output, 16), control_out (output, 22).
REQ-007 SHALL have ports flag_Z, flag_N, flag_V (outputs, 1 each) and mem_fault (output, 1, sticky).

Function
REQ-008 SHALL capture all inputs into an input register each edge unless stall=1, in which case the register holds.
REQ-009 SHALL decode the captured control word as follows:
- [8] loads: update flags
- [7:6] ALUop
- [11] mem_read
- [12] mem_write
- [13] reg_write
- [16:14] destination register number
REQ-010 SHALL drive mem_addr from the captured result and mem_wdata from the captured data_Rd; mem_we=mem_write.
REQ-011 SHALL implement FSM states IDLE, WAIT, FAULT; reset state is IDLE.
REQ-012 In IDLE with mem_read or mem_write captured, SHALL assert mem_req combinationally; if mem_ack=1 in the same cycle the access completes with zero stall, otherwise stall=1 and the next state is WAIT.
REQ-013 In WAIT, SHALL hold mem_req=1, stall=1 and constant address/data, and increment a 8-bit wait counter each cycle; mem_ack=1 completes the access (stall=0 that cycle, next state IDLE, counter cleared).
REQ-014 If the counter reaches 255 in WAIT without ack, SHALL enter FAULT: mem_fault=1, mem_req=0, stall=1 permanently until rst.
REQ-015 If both mem_read and mem_write are set, SHALL treat the access as a write (mem_we=1) and suppress writeback.
REQ-016 SHALL register writeback outputs with 1-cycle latency after completion: wb_data=mem_rdata for mem_read, else captured result; wb_en=reg_write; wb_num=[16:14]; control_out=captured control.
REQ-017 While stall=1, SHALL load a bubble into the writeback register: wb_en=0, control_out=0.
REQ-018 mem_ack arriving in IDLE with no access pending SHALL be ignored.

Reset
REQ-019 On rst, SHALL zero the input register, writeback register, counter, flags and mem_fault, and set the FSM to IDLE; mem_req=0 and stall=0 the cycle after rst is asserted, even when an access is in progress.

Configuration
REQ-020 With macro STATUS_FLAGS_EN defined, SHALL register flags when loads=1 and the stage is not stalled:
- Z=(result==0)
- N=result[15]
- V for ALUop 00: Rn_hi==Rm_hi && result[15]!=Rn_hi
- V for ALUop 01: Rn_hi!=Rm_hi && result[15]!=Rn_hi
- V for other ALUop values: 0
REQ-021 Without STATUS_FLAGS_EN, flag_Z, flag_N and flag_V SHALL be tied to 0 and no flag registers SHALL exist.

Structure
REQ-022 A shared package SHALL hold control-bit index constants, FSM state typedef (2-bit enum), and WAIT_LIMIT=255.
REQ-023 The FSM and wait counter SHALL be one sub-module, mem_access_ctrl; input and writeback registers use the team vDFF.

Verification
REQ-024 ALU op, reg_write=1, dest 3, result 0x1234 -> next cycle wb_en=1, wb_num=3, wb_data=0x1234, stall never high.
REQ-025 mem_read, addr 0x0040, ack after 3 cycles with rdata 0xBEEF -> stall high 3 cycles, mem_req held 4 cycles, then wb_data=0xBEEF, with bubbles (wb_en=0) during the stall.
REQ-026 mem_write, addr 0x0010, Rd 0x00FF, ack same cycle -> mem_we=1, mem_wdata=0x00FF, zero stall, wb_en=0.
REQ-027 Access never acked -> after 255 WAIT cycles mem_fault=1, mem_req=0, stall stays 1; rst then clears all to IDLE.
REQ-028 STATUS_FLAGS_EN defined, ALUop 01, loads=1, Rn_hi=0, Rm_hi=1, result 0x8000 -> Z=0, N=1, V=1; result 0x0000 -> Z=1, V=0.
REQ-029 rst asserted mid-WAIT -> next cycle mem_req=0, stall=0, wb_en=0, FSM IDLE.
